// File: rtl/cache_pkg.sv
// Shared definitions for the cache writeback path: FSM encoding, block geometry and
// the grant-timeout length used when WB_GRANT_TIMEOUT_EN is defined.
package cache_pkg;

    localparam int unsigned WORDS_PER_BLOCK   = 8;
    localparam int unsigned BLOCK_OFFSET_BITS = 4;
    localparam int unsigned WB_TIMEOUT_CYCLES = 16;
    localparam int unsigned CNT_W             = $clog2(WORDS_PER_BLOCK);

    localparam logic [15:0] BLOCK_BASE_MASK = ~((16'd1 << BLOCK_OFFSET_BITS) - 16'd1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StWrite = 2'd2,
        StDone  = 2'd3
    } wb_state_e;

    // Word offsets are 2-byte aligned: word n lives at base + 2n.
    function automatic logic [15:0] word_addr(input logic [15:0] base,
                                              input logic [CNT_W-1:0] cnt);
        return base | 16'({cnt, 1'b0});
    endfunction

endpackage

// File: rtl/wb_word_counter.sv
// Word index within the block being written back; saturates at the last word.
module wb_word_counter
    import cache_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             incr,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign last = (cnt_q == CNT_W'(WORDS_PER_BLOCK - 1));
    assign cnt  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (incr && !last) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cache_writeback_fsm.sv
// Writes a dirty victim block back to memory one word at a time (LOAD then WRITE per word).
// Optional feature: define WB_GRANT_TIMEOUT_EN to abort a block whose write is never granted.
module cache_writeback_fsm
    import cache_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        evict_req,
    input  logic [15:0] evict_address,
    input  logic [15:0] cache_data_in,
    input  logic        mem_grant,
    output logic        fsm_busy,
    output logic [15:0] cache_word_addr,
    output logic        mem_write,
    output logic [15:0] mem_address,
    output logic [15:0] mem_data_out,
    output logic        evict_done,
    output logic        evict_error
);

    wb_state_e        state_q, state_d;
    logic [15:0]      base_q, base_d;
    logic [15:0]      data_q, data_d;
    logic             cnt_clear, cnt_incr, cnt_last;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      cur_addr;
    logic             timeout;

    wb_word_counter u_word_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear),
        .incr  (cnt_incr),
        .cnt   (cnt),
        .last  (cnt_last)
    );

    assign cur_addr = word_addr(base_q, cnt);

`ifdef WB_GRANT_TIMEOUT_EN
    logic [3:0] wait_q, wait_d;
    logic       err_q;

    assign timeout     = (state_q == StWrite) && !mem_grant &&
                         (wait_q == 4'(WB_TIMEOUT_CYCLES - 1));
    assign wait_d      = ((state_q == StWrite) && !mem_grant) ? wait_q + 4'd1 : 4'd0;
    // Registered so the error pulse lands in the first IDLE cycle, after mem_write drops.
    assign evict_error = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= 4'd0;
            err_q  <= 1'b0;
        end else begin
            wait_q <= wait_d;
            err_q  <= timeout;
        end
    end
`else
    assign timeout     = 1'b0;
    assign evict_error = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        base_d          = base_q;
        data_d          = data_q;
        cnt_clear       = 1'b0;
        cnt_incr        = 1'b0;
        fsm_busy        = 1'b0;
        cache_word_addr = 16'h0000;
        mem_write       = 1'b0;
        mem_address     = 16'h0000;
        mem_data_out    = 16'h0000;
        evict_done      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (evict_req) begin
                    base_d    = evict_address & BLOCK_BASE_MASK;
                    cnt_clear = 1'b1;
                    state_d   = StLoad;
                end
            end
            StLoad: begin
                fsm_busy        = 1'b1;
                cache_word_addr = cur_addr;
                data_d          = cache_data_in;
                state_d         = StWrite;
            end
            StWrite: begin
                fsm_busy     = 1'b1;
                mem_write    = 1'b1;
                mem_address  = cur_addr;
                mem_data_out = data_q;
                if (mem_grant) begin
                    if (cnt_last) begin
                        state_d = StDone;
                    end else begin
                        cnt_incr = 1'b1;
                        state_d  = StLoad;
                    end
                end else if (timeout) begin
                    state_d = StIdle;
                end
            end
            StDone: begin
                fsm_busy   = 1'b1;
                evict_done = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            base_q  <= 16'h0000;
            data_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_cache_writeback_fsm.sv
// Directed bench for cache_writeback_fsm with a write scoreboard fed by a cache data model.
module tb_cache_writeback_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        evict_req = 1'b0;
    logic [15:0] evict_address = 16'h0000;
    logic [15:0] cache_data_in;
    logic        mem_grant = 1'b0;
    logic        fsm_busy;
    logic [15:0] cache_word_addr;
    logic        mem_write;
    logic [15:0] mem_address;
    logic [15:0] mem_data_out;
    logic        evict_done;
    logic        evict_error;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int wr_cnt   = 0;
    logic [31:0] exp_q[$];

    cache_writeback_fsm dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .evict_req       (evict_req),
        .evict_address   (evict_address),
        .cache_data_in   (cache_data_in),
        .mem_grant       (mem_grant),
        .fsm_busy        (fsm_busy),
        .cache_word_addr (cache_word_addr),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_data_out    (mem_data_out),
        .evict_done      (evict_done),
        .evict_error     (evict_error)
    );

    always #5 clk = ~clk;

    // Cache contents: word i of a block at page P holds {P, 8'hA0 + i}.
    function automatic logic [15:0] cache_model(input logic [15:0] a);
        return {a[15:8], 8'h00} + 16'h00A0 + {13'b0, a[3:1]};
    endfunction

    assign cache_data_in = cache_model(cache_word_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (evict_done) done_cnt++;
            if (evict_error) err_cnt++;
            if (mem_write && mem_grant) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {mem_address, mem_data_out}, 32'h0);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check("wr_addr", {16'h0, mem_address}, {16'h0, e[31:16]});
                    check("wr_data", {16'h0, mem_data_out}, {16'h0, e[15:0]});
                end
            end
        end
    end

    function automatic logic [31:0] all_outs();
        return {fsm_busy, mem_write, evict_done, evict_error, 12'h0, mem_address}
               | {16'h0, mem_data_out} | {16'h0, cache_word_addr};
    endfunction

    // Issues one request and runs until evict_done; lat is the cycle of evict_done counted
    // from the accepting edge (0 if it never arrived).
    task automatic run_block(input logic [15:0] addr, input int stall, input bit mid_req,
                             output int lat);
        logic [15:0] b;
        int left;
        b = addr & 16'hFFF0;
        for (int i = 0; i < 8; i++) begin
            logic [15:0] wa;
            wa = b | 16'(i * 2);
            exp_q.push_back({wa, cache_model(wa)});
        end
        evict_address = addr;
        evict_req = 1'b1;
        mem_grant = 1'b1;
        tick();
        evict_req = 1'b0;
        lat = 0;
        left = stall;
        for (int k = 1; k <= 60; k++) begin
            if (evict_done) begin
                lat = k;
                break;
            end
            if (mid_req && k == 5) begin
                evict_req = 1'b1;
                evict_address = 16'h0700;
            end else begin
                evict_req = 1'b0;
            end
            if (mem_write && mem_address == (b | 16'h0004) && left > 0) begin
                check("stall_data", {16'h0, mem_data_out}, {16'h0, cache_model(b | 16'h0004)});
                check("stall_busy", {31'h0, fsm_busy}, 32'h1);
                mem_grant = 1'b0;
                left--;
            end else begin
                mem_grant = 1'b1;
            end
            tick();
        end
        evict_req = 1'b0;
    endtask

    initial begin
        int lat;
        int d0, w0;
        bit found;

        #3;
        check("reset_outputs", all_outs(), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic block, grant always high.
        d0 = done_cnt; w0 = wr_cnt;
        run_block(16'h003F, 0, 1'b0, lat);
        check("basic_latency", lat, 17);
        tick();
        check("basic_writes", wr_cnt - w0, 8);
        check("basic_done", done_cnt - d0, 1);
        check("basic_queue_empty", exp_q.size(), 0);
        check("idle_outputs", all_outs(), 32'h0);

        // Grant withheld for 3 cycles on word 2.
        run_block(16'h0030, 3, 1'b0, lat);
        check("stall_latency", lat, 20);
        tick();

        // Second request mid-writeback must be ignored.
        d0 = done_cnt; w0 = wr_cnt;
        run_block(16'h0500, 0, 1'b1, lat);
        check("midreq_latency", lat, 17);
        tick();
        tick();
        check("midreq_writes", wr_cnt - w0, 8);
        check("midreq_done", done_cnt - d0, 1);
        check("midreq_idle", {31'h0, fsm_busy}, 32'h0);

        // Back-to-back: second request in the first IDLE cycle after DONE.
        d0 = done_cnt; w0 = wr_cnt;
        run_block(16'h0100, 0, 1'b0, lat);
        check("b2b_first_latency", lat, 17);
        tick();
        check("b2b_first_idle", {31'h0, fsm_busy}, 32'h0);
        run_block(16'h0200, 0, 1'b0, lat);
        check("b2b_second_latency", lat, 17);
        tick();
        check("b2b_writes", wr_cnt - w0, 16);
        check("b2b_done", done_cnt - d0, 2);
        check("b2b_queue_empty", exp_q.size(), 0);

        // Asynchronous reset while word 4 is being written.
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic [15:0] wa;
            wa = 16'h0300 | 16'(i * 2);
            exp_q.push_back({wa, cache_model(wa)});
        end
        evict_address = 16'h0300;
        evict_req = 1'b1;
        mem_grant = 1'b1;
        tick();
        evict_req = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (mem_write && mem_address == 16'h0308) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("rst_word4_seen", {31'h0, found}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_outputs", all_outs(), 32'h0);
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        w0 = wr_cnt;
        for (int k = 0; k < 20; k++) tick();
        check("rst_no_more_writes", wr_cnt - w0, 0);
        check("rst_idle", all_outs(), 32'h0);

        // Grant stuck low.
        begin
            int wcnt;
            d0 = done_cnt;
            wcnt = 0;
            evict_address = 16'h0400;
            evict_req = 1'b1;
            mem_grant = 1'b0;
            tick();
            evict_req = 1'b0;
            for (int k = 0; k < 40; k++) begin
                if (mem_write) wcnt++;
                else if (wcnt > 0) break;
                tick();
            end
`ifdef WB_GRANT_TIMEOUT_EN
            check("to_write_cycles", wcnt, 16);
            check("to_error_pulse", {31'h0, evict_error}, 32'h1);
            check("to_busy_low", {31'h0, fsm_busy}, 32'h0);
            tick();
            check("to_error_one_cycle", {31'h0, evict_error}, 32'h0);
            check("to_still_idle", {31'h0, fsm_busy}, 32'h0);
            check("to_error_count", err_cnt, 1);
            check("to_no_done", done_cnt - d0, 0);
`else
            check("nto_still_writing", {31'h0, mem_write}, 32'h1);
            check("nto_busy", {31'h0, fsm_busy}, 32'h1);
            check("nto_addr_held", {16'h0, mem_address}, 32'h0400);
            check("nto_no_error", err_cnt, 0);
            check("nto_no_done", done_cnt - d0, 0);
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            tick();
            check("nto_recovered", all_outs(), 32'h0);
`endif
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_writeback_fsm.md
CACHE_WRITEBACK_FSM -- requirements
Module: cache_writeback_fsm

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, rising-edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port evict_req, input, 1 bit: request to write back a dirty victim block.
REQ-004 SHALL have port evict_address, input, 16 bits: victim block address; bits [3:0] ignored.
REQ-005 SHALL have port cache_data_in, input, 16 bits: word read combinationally from the cache data array at cache_word_addr.
REQ-006 SHALL have port mem_grant, input, 1 bit: arbiter accepts the current memory write this cycle.
REQ-007 SHALL have port fsm_busy, output, 1 bit: writeback in progress (pipeline stall).
REQ-008 SHALL have port cache_word_addr, output, 16 bits: data-array read address.
REQ-009 SHALL have port mem_write, output, 1 bit: memory write request.
REQ-010 SHALL have ports mem_address and mem_data_out, outputs, 16 bits each: write address and data.
REQ-011 SHALL have port evict_done, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port evict_error, output, 1 bit: one-cycle timeout-abort pulse (see REQ-025).

Function
REQ-013 SHALL implement the states IDLE, LOAD, WRITE and DONE.
REQ-014 IDLE: on evict_req=1 at a rising edge, SHALL latch base = evict_address & 16'hFFF0, clear the 3-bit word counter, and go to LOAD.
REQ-015 LOAD (1 cycle): SHALL drive cache_word_addr = base | {cnt,1'b0}, capture cache_data_in into a data register, and go to WRITE.
REQ-016 WRITE: SHALL drive mem_write=1, mem_address = base | {cnt,1'b0} and mem_data_out = the data register, all held stable until mem_grant=1.
REQ-017 WRITE with mem_grant=1: SHALL go to DONE if cnt==7, otherwise increment cnt and go to LOAD.
REQ-018 DONE: SHALL assert evict_done for exactly one cycle, then go to IDLE.
REQ-019 fsm_busy SHALL be 1 in LOAD, WRITE and DONE.
REQ-020 evict_req SHALL be ignored while not in IDLE; a new request is accepted in the first IDLE cycle after DONE.
REQ-021 With mem_grant held at 1, one block SHALL take 17 cycles after the accepting edge: 8 words x 2 cycles, plus 1 DONE cycle.
REQ-022 Words SHALL be written in ascending order, offsets 0,2,...,E; the counter SHALL NOT wrap past 7.
REQ-023 Outside WRITE, mem_write SHALL be 0; mem_address, mem_data_out and cache_word_addr SHALL be 0 when in IDLE.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE, cnt=0, base=0, data register=0, and all outputs to 0, including mid-writeback; no further writes of the aborted block SHALL be issued.

Configuration
REQ-025 With WB_GRANT_TIMEOUT_EN defined: a 4-bit wait counter SHALL count WRITE cycles without mem_grant; on the 16th, the block SHALL drop mem_write, pulse evict_error for one cycle and go to IDLE without evict_done.
REQ-026 Without WB_GRANT_TIMEOUT_EN: the block SHALL wait in WRITE indefinitely, and evict_error SHALL be tied to 0.

Structure
REQ-027 The shared package cache_pkg SHALL hold the state encoding, WORDS_PER_BLOCK=8, BLOCK_OFFSET_BITS=4 and WB_TIMEOUT_CYCLES=16.
REQ-028 The word counter SHALL be a sub-module, wb_word_counter, with 3-bit counter, clear, increment and last output.

Verification
REQ-029 Reset, then evict_req with evict_address=16'h003F, mem_grant=1, cache data word i = 16'hA0+i -> writes to 0030,0032,...,003E with data 00A0..00A7, and evict_done in cycle 17.
REQ-030 mem_grant low for 3 cycles on word 2 -> mem_write, mem_address=0x0034 and data held stable for those 3 cycles; total latency 20 cycles.
REQ-031 evict_req pulsed again mid-writeback -> ignored; exactly 8 writes occur, and one evict_done pulse.
REQ-032 rst_n=0 during word 4 -> all outputs 0 asynchronously; no further mem_write after release.
REQ-033 WB_GRANT_TIMEOUT_EN defined, mem_grant stuck 0 -> evict_error pulse after 16 WRITE cycles, fsm_busy=0 next cycle, and no evict_done.
REQ-034 Back-to-back requests (0x0100, then 0x0200 issued in the first IDLE cycle) -> 16 writes in order, and two evict_done pulses.
